// File: rtl/switch_debouncer.sv
// Two-flop synchroniser followed by a whole-word debouncer for the slide-switch bus.
// A new value is committed only after STABLE_CYCLES identical synchronised samples.
module switch_debouncer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             sw_changed,
  output logic [WIDTH-1:0] changed_bits,
  output logic             busy
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    SETTLING
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_candidate;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sw_out;
  logic             r_sw_changed;
  logic [WIDTH-1:0] r_changed_bits;
  logic             r_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_sync1        <= '0;
      r_sync2        <= '0;
      r_candidate    <= '0;
      r_count        <= '0;
      r_sw_out       <= '0;
      r_sw_changed   <= 1'b0;
      r_changed_bits <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_sync1        <= sw_in;
      r_sync2        <= r_sync1;
      // Strobe and mask are overridden only on a commit edge.
      r_sw_changed   <= 1'b0;
      r_changed_bits <= '0;
      case (r_state)
        IDLE: begin
          if (r_sync2 != r_sw_out) begin
            r_candidate <= r_sync2;
            r_count     <= CNT_ONE;
            r_state     <= SETTLING;
            r_busy      <= 1'b1;
          end else begin
            r_count <= '0;
          end
        end
        SETTLING: begin
          if (r_sync2 == r_sw_out) begin
            r_count <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_sync2 != r_candidate) begin
            r_candidate <= r_sync2;
            r_count     <= CNT_ONE;
          end else if (r_count == CNT_LAST) begin
            r_sw_out       <= r_candidate;
            r_changed_bits <= r_sw_out ^ r_candidate;
            r_sw_changed   <= 1'b1;
            r_count        <= '0;
            r_state        <= IDLE;
            r_busy         <= 1'b0;
          end else begin
            r_count <= r_count + CNT_ONE;
          end
        end
        default: begin
          r_count <= '0;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sw_out       = r_sw_out;
  assign sw_changed   = r_sw_changed;
  assign changed_bits = r_changed_bits;
  assign busy         = r_busy;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random bouncing, checked every
// cycle against a sample-history model (commit when the last S synced samples agree).
module tb_switch_debouncer;

  localparam int unsigned S    = 4;
  localparam int          NMAX = 4096;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] sw_in;
  logic [7:0] sw_out;
  logic       sw_changed;
  logic [7:0] changed_bits;
  logic       busy;

  switch_debouncer #(
    .WIDTH        (8),
    .STABLE_CYCLES(S)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sw_in       (sw_in),
    .sw_out      (sw_out),
    .sw_changed  (sw_changed),
    .changed_bits(changed_bits),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: raw input history, synchronised-sample history, committed word.
  logic [7:0] in_hist [0:NMAX-1];
  logic [7:0] samp    [0:NMAX-1];
  int         edge_n   = 0;
  int         last_rst = 0;
  logic [7:0] m_out    = '0;
  logic       m_chg    = 1'b0;
  logic [7:0] m_bits   = '0;
  logic       m_busy   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
    end
  endtask

  // A synchronised sample at edge n is the raw input two edges earlier, or 0 if a
  // reset occurred in between. A commit happens when the last S samples (all after
  // the latest reset) are identical and differ from the committed word.
  task automatic model_edge(input logic [7:0] v, input logic r);
    logic commit;
    in_hist[edge_n] = v;
    if (r) begin
      last_rst       = edge_n;
      samp[edge_n]   = '0;
      m_out          = '0;
      m_chg          = 1'b0;
      m_bits         = '0;
      m_busy         = 1'b0;
    end else begin
      samp[edge_n] = (edge_n - 2 > last_rst) ? in_hist[edge_n-2] : 8'h00;
      commit = (edge_n - last_rst >= S) && (samp[edge_n] != m_out);
      for (int k = 1; k < S; k++)
        if (commit && samp[edge_n-k] != samp[edge_n]) commit = 1'b0;
      if (commit) begin
        m_bits = m_out ^ samp[edge_n];
        m_out  = samp[edge_n];
        m_chg  = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_bits = '0;
        m_chg  = 1'b0;
        m_busy = (samp[edge_n] != m_out);
      end
    end
  endtask

  task automatic step(input logic [7:0] v, input logic r);
    sw_in = v;
    reset = r;
    @(posedge clock);
    #1;
    model_edge(v, r);
    check_eq("sw_out", 32'(sw_out), 32'(m_out));
    check_eq("sw_changed", 32'(sw_changed), 32'(m_chg));
    check_eq("changed_bits", 32'(changed_bits), 32'(m_bits));
    check_eq("busy", 32'(busy), 32'(m_busy));
    edge_n++;
  endtask

  task automatic hold(input logic [7:0] v, input int cycles, output int strobes, output int first_pos);
    strobes   = 0;
    first_pos = 0;
    for (int i = 1; i <= cycles; i++) begin
      step(v, 1'b0);
      if (sw_changed === 1'b1) begin
        strobes++;
        if (first_pos == 0) first_pos = i;
      end
    end
  endtask

  initial begin
    int         strobes;
    int         pos;
    int         busy_seen;
    logic [7:0] target;
    logic [7:0] v;

    // Reset and idle
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
    hold(8'h00, 10, strobes, pos);
    check_eq("idle_strobes", 32'(strobes), 32'd0);

    // Clean step 0x00 -> 0x35
    hold(8'h35, 10, strobes, pos);
    check_eq("step_strobes", 32'(strobes), 32'd1);
    check_eq("step_latency", 32'(pos), 32'(S + 2));
    check_eq("step_value", 32'(sw_out), 32'h35);

    // Bounce 0x34/0x35 every 2 cycles, then settle on 0x34
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      step(((i / 2) % 2 == 0) ? 8'h34 : 8'h35, 1'b0);
      if (sw_changed === 1'b1) strobes++;
    end
    check_eq("toggle_strobes", 32'(strobes), 32'd0);
    hold(8'h34, 10, strobes, pos);
    check_eq("settle_strobes", 32'(strobes), 32'd1);
    check_eq("settle_latency", 32'(pos), 32'(S + 2));

    // Short glitch to 0x30 returns without a commit
    strobes   = 0;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step((i < 2) ? 8'h30 : 8'h34, 1'b0);
      if (sw_changed === 1'b1) strobes++;
      if (busy === 1'b1) busy_seen = 1;
    end
    check_eq("glitch_strobes", 32'(strobes), 32'd0);
    check_eq("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check_eq("glitch_busy_end", 32'(busy), 32'd0);
    check_eq("glitch_value", 32'(sw_out), 32'h34);

    // Reset while settling on 0xFF, then release with 0xFF held
    hold(8'hFF, 4, strobes, pos);
    check_eq("pre_reset_strobes", 32'(strobes), 32'd0);
    check_eq("pre_reset_busy", 32'(busy), 32'd1);
    step(8'hFF, 1'b1);
    check_eq("mid_reset_out", 32'(sw_out), 32'h00);
    hold(8'hFF, 10, strobes, pos);
    check_eq("post_reset_strobes", 32'(strobes), 32'd1);
    check_eq("post_reset_latency", 32'(pos), 32'(S + 2));

    // Release with 0xA5 on the pins
    step(8'hA5, 1'b1);
    step(8'hA5, 1'b1);
    hold(8'hA5, 10, strobes, pos);
    check_eq("release_strobes", 32'(strobes), 32'd1);
    check_eq("release_latency", 32'(pos), 32'(S + 2));
    check_eq("release_value", 32'(sw_out), 32'hA5);

    // Random bouncing, occasional resets
    target = 8'hA5;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0)
        target = ($urandom_range(0, 1) == 1) ? 8'($urandom) : target ^ 8'(1 << $urandom_range(0, 7));
      v = ($urandom_range(0, 5) == 0) ? target ^ 8'(1 << $urandom_range(0, 7)) : target;
      step(v, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions the raw slide-switch bus before it reaches the operand logic (math block and seven-segment decoder). It synchronises every switch into the board clock domain and debounces the bus as a single word. It publishes a stable, glitch-free copy of the switches, plus a one-cycle change strobe and a mask of the bits that changed. It sits between the `sw` pins and the A/B operand split in the top level.

## Interface
Parameters:
- `WIDTH`, 8, number of switch bits conditioned.
- `STABLE_CYCLES`, 16, number of consecutive identical synchronised samples required before a new value is committed. Must be ≥ 2. Top level passes a larger value for hardware; benches use a small value.

Ports:
- `clock`  in  1  board clock (100 MHz); all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sw_in`  in  WIDTH  raw, asynchronous switch pins.
- `sw_out`  out  WIDTH  debounced, committed switch value (registered).
- `sw_changed`  out  1  one-cycle strobe, high in the cycle after a commit edge.
- `changed_bits`  out  WIDTH  `old sw_out ^ new sw_out`; valid only while `sw_changed`=1, otherwise 0.
- `busy`  out  1  high while a candidate value is settling.

## Operation
- Synchroniser: two-flop chain `sync1 <= sw_in`, `sync2 <= sync1`. Only `sync2` is used downstream.
- Internal state: `candidate` (WIDTH), `count` (width `$clog2(STABLE_CYCLES+1)`), and FSM state IDLE / SETTLING.
- IDLE:
  - If `sync2 == sw_out`, stay in IDLE; `count` = 0.
  - Else: `candidate <= sync2`, `count <= 1`, go to SETTLING.
- SETTLING, evaluated in priority order:
  1. `sync2 == sw_out` (the bounce returned to the committed value): go to IDLE, `count <= 0`, no strobe.
  2. `sync2 != candidate` (a new bounce value): `candidate <= sync2`, `count <= 1`, stay in SETTLING.
  3. `count == STABLE_CYCLES-1`: `sw_out <= candidate`, `changed_bits <= sw_out ^ candidate`, `sw_changed <= 1`, `count <= 0`, go to IDLE.
  4. Otherwise: `count <= count + 1`.
- `sw_changed` and `changed_bits` are cleared on every edge on which no commit occurs, so they are strictly one-cycle.
- `busy` is registered and equals (state == SETTLING).
- Multi-bit changes are debounced as one word. Any bit bouncing restarts the whole count, and a commit updates all changed bits simultaneously. `sw_out` never shows a partial update.
- Reset, whether at any time or mid-SETTLING: `sync1`, `sync2`, `candidate`, `sw_out`, `changed_bits` = 0; `count` = 0; state IDLE; `sw_changed` = 0; `busy` = 0. The pending candidate is discarded.
- After reset release with non-zero switches: the value is treated as a normal change from 0. It commits after the standard latency and produces one strobe.

## Timing
- Latency: let `sw_in` change and then hold steady, and let edge E be the first edge that samples the new value into `sync1`.
  - Edge E+1: `sync2` holds the new value.
  - Edge E+2: FSM enters SETTLING (count = 1); `busy` = 1.
  - Edge E+1+STABLE_CYCLES: commit; `sw_out` takes the new value, and `sw_changed` = 1 for exactly that cycle.
  - Total: STABLE_CYCLES+2 edges from E inclusive.
- `busy` drops on the commit edge.
- A bounce restarts the count on the edge where `sync2` changes. The commit then needs STABLE_CYCLES further matching samples, counted from that edge.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around possible.
- Back-to-back changes: a new difference seen on the edge right after a commit starts SETTLING immediately. The minimum spacing between strobes is STABLE_CYCLES edges.
- Reset wins over every other event on the same edge.

## Test plan
All scenarios run with STABLE_CYCLES=4.
- Reset with `sw_in`=0x00 held for 3 cycles → `sw_out`=0x00, `sw_changed`=0, `changed_bits`=0x00, `busy`=0. All stay so for 10 further cycles.
- Step `sw_in` 0x00→0x35, held:
  - `busy` rises at edge E+2.
  - `sw_out`=0x35 and `sw_changed`=1 for one cycle at edge E+5, with `changed_bits`=0x35.
  - `busy`=0 afterwards.
- From 0x35, toggle `sw_in` 0x34/0x35 alternately every 2 cycles for 12 cycles, then hold 0x34 → no strobe during the toggling. Exactly one strobe follows, 5 edges after 0x34 is first held, with `sw_out`=0x34 and `changed_bits`=0x01.
- From 0x34, glitch `sw_in` to 0x30 for 2 cycles, then return to 0x34 → `busy` pulses high then low; no strobe; `sw_out` stays 0x34.
- Reset mid-operation: start a 0x34→0xFF change and assert `reset` when `busy`=1 (count=2) → next edge gives `sw_out`=0x00 and `busy`=0 with no strobe. After release with 0xFF held, a commit of 0xFF follows 6 edges later with `changed_bits`=0xFF.
- Reset release with `sw_in`=0xA5 → single strobe at the 6th edge after release, `sw_out`=0xA5, `changed_bits`=0xA5.
